// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: a WIDTH-bit word FIFO feeding a bit shifter
// that streams words back-to-back onto dout, with a fixed idle level between bursts.
module seq_serializer #(
   parameter int       WIDTH     = 8,
   parameter int       DEPTH     = 4,
   parameter bit       MSB_FIRST = 1'b1,
   parameter logic     IDLE_BIT  = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       dout,
   output logic                       dout_valid,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, nxt_state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [WIDTH-1:0] sh, nxt_sh, head;
   logic [CW-1:0]    cnt, nxt_cnt;
   logic             nxt_dout, nxt_dv;
   logic             push, pop, last_bit, have_word;

   assign in_ready  = (level < LW'(DEPTH));
   assign push      = in_valid && in_ready;
   assign head      = mem[rptr];
   assign have_word = (level != '0);
   assign last_bit  = (cnt == CW'(WIDTH));
   assign busy      = (state == SHIFT) || have_word;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt_state;
   end

   // next-state logic
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (have_word) nxt_state = SHIFT;
         SHIFT:   if (last_bit && !have_word) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // output / datapath decode; pop decisions see level before any same-edge push
   always_comb begin
      pop      = 1'b0;
      nxt_sh   = sh;
      nxt_dout = IDLE_BIT;
      nxt_dv   = 1'b0;
      nxt_cnt  = '0;
      if ((state == IDLE || last_bit) && have_word) begin
         pop     = 1'b1;
         nxt_dv  = 1'b1;
         nxt_cnt = CW'(1);
         if (MSB_FIRST) begin
            nxt_dout = head[WIDTH-1];
            nxt_sh   = {head[WIDTH-2:0], 1'b0};
         end else begin
            nxt_dout = head[0];
            nxt_sh   = {1'b0, head[WIDTH-1:1]};
         end
      end else if (state == SHIFT && !last_bit) begin
         nxt_dv  = 1'b1;
         nxt_cnt = cnt + CW'(1);
         if (MSB_FIRST) begin
            nxt_dout = sh[WIDTH-1];
            nxt_sh   = {sh[WIDTH-2:0], 1'b0};
         end else begin
            nxt_dout = sh[0];
            nxt_sh   = {1'b0, sh[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr       <= '0;
         rptr       <= '0;
         level      <= '0;
         sh         <= '0;
         cnt        <= '0;
         dout       <= IDLE_BIT;
         dout_valid <= 1'b0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         sh         <= nxt_sh;
         cnt        <= nxt_cnt;
         dout       <= nxt_dout;
         dout_valid <= nxt_dv;
      end
   end
endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: an MSB-first instance and an LSB-first instance.
module tb_seq_serializer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data_a = '0, in_data_b = '0;
   logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic       in_ready_a, in_ready_b, dout_a, dout_b, dv_a, dv_b, busy_a, busy_b;
   logic [2:0] level_a, level_b;

   int checks = 0, failures = 0;
   bit qa[$], qb[$];
   int run_a = 0, last_run_a = 0;

   always #5 clk = ~clk;

   seq_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .dout(dout_a), .dout_valid(dv_a), .busy(busy_a), .level(level_a));

   seq_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .dout(dout_b), .dout_valid(dv_b), .busy(busy_b), .level(level_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitors: every valid serial bit is matched against the next expected bit
   always @(negedge clk) begin
      if (rst && dv_a) begin
         if (qa.size() == 0) chk("a_unexpected_bit", 32'(dout_a), 32'hdead);
         else chk("a_bit", 32'(dout_a), 32'(qa.pop_front()));
      end
      if (rst && dv_b) begin
         if (qb.size() == 0) chk("b_unexpected_bit", 32'(dout_b), 32'hdead);
         else chk("b_bit", 32'(dout_b), 32'(qb.pop_front()));
      end
   end

   // length of the most recent contiguous dout_valid run on instance A
   always @(negedge clk) begin
      if (!rst) run_a <= 0;
      else if (dv_a) run_a <= run_a + 1;
      else begin
         if (run_a > 0) last_run_a <= run_a;
         run_a <= 0;
      end
   end

   // offer a word (valid held until accepted); expected bits go to the scoreboard on acceptance
   task automatic send(input bit sel, input logic [7:0] w, output int stalls);
      stalls = 0;
      if (!sel) begin in_data_a = w; in_valid_a = 1'b1; end
      else      begin in_data_b = w; in_valid_b = 1'b1; end
      while (!(sel ? in_ready_b : in_ready_a) && stalls < 50) begin
         @(negedge clk);
         stalls++;
      end
      if (!(sel ? in_ready_b : in_ready_a)) chk("send_timeout", 32'(stalls), 32'd0);
      else for (int b = 0; b < 8; b++) begin
         if (!sel) qa.push_back(w[7-b]);
         else      qb.push_back(w[b]);
      end
      @(negedge clk);
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_a || busy_b) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy_a || busy_b) chk("idle_timeout", 32'(n), 32'd0);
      @(negedge clk);
      @(negedge clk);
   endtask

   logic [7:0] words [6];
   int st;

   initial begin
      // 1: reset with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid_a = 1'($urandom); in_data_a = 8'($urandom);
         in_valid_b = 1'($urandom); in_data_b = 8'($urandom);
      end
      chk("rst_dout", 32'(dout_a), 32'd1);
      chk("rst_dv", 32'(dv_a), 32'd0);
      chk("rst_in_ready", 32'(in_ready_a), 32'd1);
      chk("rst_level", 32'(level_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_b_dout", 32'(dout_b), 32'd1);
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 2: single word A5, MSB first, first bit one edge after the push
      send(1'b0, 8'hA5, st);
      chk("single_first_bit_pending", 32'(dv_a), 32'd0);
      @(negedge clk);
      chk("single_latency_dv", 32'(dv_a), 32'd1);
      chk("single_latency_bit", 32'(dout_a), 32'd1);
      wait_idle();
      chk("single_run", 32'(last_run_a), 32'd8);
      chk("single_idle_dout", 32'(dout_a), 32'd1);
      chk("single_idle_busy", 32'(busy_a), 32'd0);

      // 3: back-to-back stream of four words, gapless
      send(1'b0, 8'h00, st);
      send(1'b0, 8'hFF, st);
      send(1'b0, 8'h0F, st);
      send(1'b0, 8'hF0, st);
      wait_idle();
      chk("stream_run", 32'(last_run_a), 32'd32);

      // 4: back-pressure, valid held for six words
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            chk("bp_level_full", 32'(level_a), 32'd4);
            chk("bp_not_ready", 32'(in_ready_a), 32'd0);
         end
         send(1'b0, words[i], st);
         if (i == 5) chk("bp_stall_cycles", 32'(st), 32'd5);
         else        chk("bp_no_stall", 32'(st), 32'd0);
      end
      wait_idle();
      chk("bp_run", 32'(last_run_a), 32'd48);
      chk("bp_queue_drained", 32'(qa.size()), 32'd0);

      // 5: reset mid-word with two words queued
      send(1'b0, 8'hC3, st);
      send(1'b0, 8'h5A, st);
      send(1'b0, 8'h99, st);
      @(posedge clk);
      #2;
      chk("mid_level_before", 32'(level_a), 32'd2);
      rst = 1'b0;
      #1;
      chk("mid_rst_dout", 32'(dout_a), 32'd1);
      chk("mid_rst_dv", 32'(dv_a), 32'd0);
      chk("mid_rst_level", 32'(level_a), 32'd0);
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      qa.delete();
      @(negedge clk);
      rst = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dv_a) seen++;
         end
         chk("mid_no_residual", 32'(seen), 32'd0);
      end
      chk("mid_level_after", 32'(level_a), 32'd0);

      // 6: LSB-first instance
      send(1'b1, 8'h01, st);
      @(negedge clk);
      chk("lsb_first_bit", 32'(dout_b), 32'd1);
      send(1'b1, 8'h2A, st);
      wait_idle();
      chk("lsb_queue_drained", 32'(qb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
